vliw_fetch: RTL and testbench

Instruction-bundle fetch stage directly upstream of the vliw core; supplies one full VLIW bundle per handshake to the core's decode stage. Owns the bundle PC, issues in-order requests to instruction memory, buffers returned bundles in a small FIFO, and flushes on branch redirect from the core. Credit-based so no returned bundle is ever dropped for lack of space.

---
 rtl/vliw_pkg.sv | 18 +
 rtl/vliw_fetch_if.sv | 26 ++
 rtl/vliw_fetch_fifo.sv | 49 ++++
 rtl/vliw_fetch.sv | 117 +++++++++++
 tb/tb_vliw_fetch.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vliw_pkg.sv
// rtl/vliw_pkg.sv - bundle geometry, address/instruction/bundle types and pc alignment helper
package vliw_pkg;
  localparam int SLOTS        = 4;
  localparam int INSN_W       = 32;
  localparam int ADDR_W       = 32;
  localparam int BUNDLE_W     = SLOTS * INSN_W;
  localparam int BUNDLE_BYTES = BUNDLE_W / 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INSN_W-1:0] insn_t;
  typedef insn_t [SLOTS-1:0] bundle_t;

  localparam addr_t BUNDLE_INC = addr_t'(BUNDLE_BYTES);

  function automatic addr_t align_pc(addr_t a);
    return a & ~(BUNDLE_INC - addr_t'(1));
  endfunction
endpackage

// File: rtl/vliw_fetch_if.sv
// rtl/vliw_fetch_if.sv - imem request/response, redirect and bundle handshake signals of the fetch stage
interface vliw_fetch_if;
  import vliw_pkg::*;

  logic    imem_req;
  addr_t   imem_addr;
  logic    imem_gnt;
  logic    imem_rvalid;
  bundle_t imem_rdata;
  logic    redirect_valid;
  addr_t   redirect_pc;
  logic    bundle_valid;
  logic    bundle_ready;
  bundle_t bundle_data;
  addr_t   bundle_pc;

  modport master (
    output imem_req, imem_addr, bundle_valid, bundle_data, bundle_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, bundle_ready
  );

  modport slave (
    input  imem_req, imem_addr, bundle_valid, bundle_data, bundle_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, bundle_ready
  );
endinterface

// File: rtl/vliw_fetch_fifo.sv
// rtl/vliw_fetch_fifo.sv - synchronous bundle+pc FIFO with flush and occupancy count
module vliw_fetch_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 128,
  parameter int PC_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic [PC_W-1:0]        push_pc,
  input  logic                   pop,
  output logic [DATA_W-1:0]      head_data,
  output logic [PC_W-1:0]        head_pc,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;

  // DEPTH is a power of two, so pointers wrap without compare logic
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_pc[wr_ptr]   <= push_pc;
    end
  end

  assign head_data = mem_data[rd_ptr];
  assign head_pc   = mem_pc[rd_ptr];
  assign empty     = (count == '0);
endmodule

// File: rtl/vliw_fetch.sv
// rtl/vliw_fetch.sv - VLIW bundle fetch: pc, credit-limited imem requests, bundle FIFO, redirect flush
// VLIW_FETCH_PERF_EN adds saturating stall and flush counters.
module vliw_fetch
  import vliw_pkg::*;
#(
  parameter int    FIFO_DEPTH = 4,
  parameter addr_t RESET_PC   = '0
) (
  input  logic         clk,
  input  logic         rst,
  vliw_fetch_if.master bus
`ifdef VLIW_FETCH_PERF_EN
  ,
  output logic [31:0]  perf_stall_cnt,
  output logic [31:0]  perf_flush_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic          rst_q;
  addr_t         pc, resp_pc;
  logic [CW-1:0] outstanding, outstanding_nxt, drop, fifo_count;
  logic [CW:0]   credit_used;
  logic          fire, discard, push, pop, fifo_empty;
  logic [BUNDLE_W-1:0] head_data;
  addr_t         head_pc;

  // every in-flight or buffered bundle holds a FIFO slot, so responses never overflow
  assign credit_used  = {1'b0, outstanding} + {1'b0, fifo_count};
  assign bus.imem_req = !rst_q && (credit_used < DEPTH_C) && !bus.redirect_valid;
  assign bus.imem_addr = pc;

  assign fire    = bus.imem_req && bus.imem_gnt;
  assign discard = bus.imem_rvalid && (drop != '0);
  assign push    = bus.imem_rvalid && (drop == '0) && !bus.redirect_valid;
  assign pop     = bus.bundle_valid && bus.bundle_ready;

  always_comb begin
    outstanding_nxt = outstanding;
    if (fire && !bus.imem_rvalid)      outstanding_nxt = outstanding + 1'b1;
    else if (!fire && bus.imem_rvalid) outstanding_nxt = outstanding - 1'b1;
  end

  // resp_pc tracks the address of the oldest response that will be kept
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (bus.redirect_valid) begin
        pc      <= align_pc(bus.redirect_pc);
        resp_pc <= align_pc(bus.redirect_pc);
        drop    <= outstanding_nxt;
      end else begin
        if (fire)    pc      <= pc + BUNDLE_INC;
        if (push)    resp_pc <= resp_pc + BUNDLE_INC;
        if (discard) drop    <= drop - 1'b1;
      end
    end
  end

  vliw_fetch_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (BUNDLE_W),
    .PC_W   (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data (bus.imem_rdata),
    .push_pc   (resp_pc),
    .pop       (pop),
    .head_data (head_data),
    .head_pc   (head_pc),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.bundle_valid = !fifo_empty;
  assign bus.bundle_data  = fifo_empty ? '0 : head_data;
  assign bus.bundle_pc    = fifo_empty ? '0 : head_pc;

`ifdef VLIW_FETCH_PERF_EN
  logic [31:0] flush_inc;
  logic [32:0] flush_sum;

  // a redirect discards buffered entries not popped this cycle plus any response arriving now
  always_comb begin
    flush_inc = '0;
    if (bus.redirect_valid) flush_inc = 32'(fifo_count) - 32'(pop) + 32'(bus.imem_rvalid);
    else if (discard)       flush_inc = 32'd1;
  end
  assign flush_sum = {1'b0, perf_flush_cnt} + {1'b0, flush_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!bus.bundle_valid && bus.bundle_ready && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      perf_flush_cnt <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end
`endif

  rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rvalid |-> (outstanding != '0));
  drop_within_outstanding: assert property (@(posedge clk) disable iff (rst)
    drop <= outstanding);
endmodule

// File: tb/tb_vliw_fetch.sv
// tb/tb_vliw_fetch.sv - directed vector table plus redirect/reset corner sequences for vliw_fetch
module tb_vliw_fetch;
  import vliw_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vliw_fetch_if bus();
`ifdef VLIW_FETCH_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  vliw_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef VLIW_FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  typedef struct {
    addr_t addr;
    int    due;
  } resp_t;

  typedef struct {
    logic  rst, gnt, ready, chk;
    logic  exp_req;
    addr_t exp_addr;
    logic  exp_valid;
    addr_t exp_pc;
    logic  zero;
  } vec_t;

  resp_t pending[$];
  vec_t  vecs[$];
  int    cyc = 0;
  int    lat = 1;
  int    total = 0;
  int    bad = 0;

  function automatic bundle_t mk_bundle(addr_t a);
    bundle_t b;
    for (int i = 0; i < SLOTS; i++) b[i] = insn_t'(a ^ 32'hC0DE_0000) + insn_t'(i);
    return b;
  endfunction

  function automatic vec_t v(logic r, logic g, logic rdy, logic c, logic req, addr_t a,
                             logic val, addr_t p, logic z);
    vec_t x;
    x.rst = r; x.gnt = g; x.ready = rdy; x.chk = c; x.exp_req = req;
    x.exp_addr = a; x.exp_valid = val; x.exp_pc = p; x.zero = z;
    return x;
  endfunction

  task automatic check1(string nm, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic check32(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic checkb(string nm, bundle_t act, bundle_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // one clock: memory model records grants at the edge and drives in-order responses after it
  task automatic step();
    logic  f;
    addr_t a;
    #1;
    f = bus.imem_req && bus.imem_gnt;
    a = bus.imem_addr;
    @(posedge clk);
    cyc++;
    if (rst) pending.delete();
    else if (f === 1'b1) pending.push_back('{a, cyc + lat - 1});
    #1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    if (!rst && pending.size() != 0 && pending[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mk_bundle(pending[0].addr);
      void'(pending.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_gnt = 1'b0;
    bus.bundle_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_valid(string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.bundle_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: bundle_valid never rose within 20 cycles", nm);
    end
  endtask

  task automatic expect_first(string nm, addr_t p);
    wait_valid({nm, "_wait"});
    check32({nm, "_pc"}, bus.bundle_pc, p);
    checkb({nm, "_data"}, bus.bundle_data, mk_bundle(p));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.bundle_ready = 1'b0;

    // streaming, ready=1, 1-cycle memory
    vecs.push_back(v(1, 0, 0, 0, 0, 32'h00, 0, 32'h00, 0));
    vecs.push_back(v(0, 1, 1, 1, 0, 32'h00, 0, 32'h00, 1));
    vecs.push_back(v(0, 1, 1, 1, 1, 32'h00, 0, 32'h00, 0));
    vecs.push_back(v(0, 1, 1, 1, 1, 32'h10, 0, 32'h00, 0));
    vecs.push_back(v(0, 1, 1, 1, 1, 32'h20, 1, 32'h00, 0));
    vecs.push_back(v(0, 1, 1, 1, 1, 32'h30, 1, 32'h10, 0));
    vecs.push_back(v(0, 1, 1, 1, 1, 32'h40, 1, 32'h20, 0));
    vecs.push_back(v(0, 1, 1, 1, 1, 32'h50, 1, 32'h30, 0));
    // ready=0: four grants fill the credit, then requests stop
    vecs.push_back(v(1, 0, 0, 0, 0, 32'h00, 0, 32'h00, 0));
    vecs.push_back(v(0, 1, 0, 1, 0, 32'h00, 0, 32'h00, 1));
    vecs.push_back(v(0, 1, 0, 1, 1, 32'h00, 0, 32'h00, 0));
    vecs.push_back(v(0, 1, 0, 1, 1, 32'h10, 0, 32'h00, 0));
    vecs.push_back(v(0, 1, 0, 1, 1, 32'h20, 1, 32'h00, 0));
    vecs.push_back(v(0, 1, 0, 1, 1, 32'h30, 1, 32'h00, 0));
    vecs.push_back(v(0, 1, 0, 1, 0, 32'h40, 1, 32'h00, 0));
    vecs.push_back(v(0, 1, 0, 1, 0, 32'h40, 1, 32'h00, 0));
    vecs.push_back(v(0, 1, 0, 1, 0, 32'h40, 1, 32'h00, 0));
    vecs.push_back(v(0, 1, 0, 1, 0, 32'h40, 1, 32'h00, 0));
    // gnt low for three cycles holds the address
    vecs.push_back(v(1, 0, 0, 0, 0, 32'h00, 0, 32'h00, 0));
    vecs.push_back(v(0, 1, 1, 1, 0, 32'h00, 0, 32'h00, 1));
    vecs.push_back(v(0, 1, 1, 1, 1, 32'h00, 0, 32'h00, 0));
    vecs.push_back(v(0, 0, 1, 1, 1, 32'h10, 0, 32'h00, 0));
    vecs.push_back(v(0, 0, 1, 1, 1, 32'h10, 1, 32'h00, 0));
    vecs.push_back(v(0, 0, 1, 1, 1, 32'h10, 0, 32'h00, 0));
    vecs.push_back(v(0, 1, 1, 1, 1, 32'h10, 0, 32'h00, 0));
    vecs.push_back(v(0, 1, 1, 1, 1, 32'h20, 0, 32'h00, 0));
    vecs.push_back(v(0, 1, 1, 1, 1, 32'h30, 1, 32'h10, 0));

    lat = 1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      bus.imem_gnt = vecs[i].gnt;
      bus.bundle_ready = vecs[i].ready;
      bus.redirect_valid = 1'b0;
      #1;
      if (vecs[i].chk) begin
        check1($sformatf("v%0d_req", i), bus.imem_req, vecs[i].exp_req);
        check32($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
        check1($sformatf("v%0d_valid", i), bus.bundle_valid, vecs[i].exp_valid);
        if (vecs[i].exp_valid || vecs[i].zero) begin
          check32($sformatf("v%0d_pc", i), bus.bundle_pc, vecs[i].exp_pc);
          checkb($sformatf("v%0d_data", i), bus.bundle_data,
                 vecs[i].zero ? bundle_t'('0) : mk_bundle(vecs[i].exp_pc));
        end
      end
      step();
    end

    // redirect with two responses outstanding
    lat = 3;
    do_reset();
    bus.imem_gnt = 1'b1;
    bus.bundle_ready = 1'b1;
    step();
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_1234;
    #1;
    check1("redir_req_low", bus.imem_req, 1'b0);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    check1("redir_req", bus.imem_req, 1'b1);
    check32("redir_addr", bus.imem_addr, 32'h0000_1230);
    expect_first("redir_first", 32'h0000_1230);

    // redirect while FIFO full and the core pops in the same cycle
    lat = 1;
    do_reset();
    bus.imem_gnt = 1'b1;
    for (int i = 0; i < 7; i++) step();
    #1;
    check1("full_valid", bus.bundle_valid, 1'b1);
    check1("full_req_low", bus.imem_req, 1'b0);
    bus.bundle_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0080;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    check1("flush_empty", bus.bundle_valid, 1'b0);
    check32("flush_addr", bus.imem_addr, 32'h0000_0080);
`ifdef VLIW_FETCH_PERF_EN
    check32("perf_flush", perf_flush_cnt, 32'd3);
`endif
    expect_first("flush_first", 32'h0000_0080);

    // back-to-back redirects: the later target wins
    lat = 3;
    do_reset();
    bus.imem_gnt = 1'b1;
    bus.bundle_ready = 1'b1;
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    step();
    bus.redirect_pc = 32'h0000_0300;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    check32("b2b_addr", bus.imem_addr, 32'h0000_0300);
    expect_first("b2b_first", 32'h0000_0300);

    // address wrap at the top of the address space
    lat = 1;
    do_reset();
    bus.imem_gnt = 1'b1;
    bus.bundle_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    check32("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFF0);
    step();
    #1;
    check32("wrap_addr_zero", bus.imem_addr, 32'h0000_0000);
    expect_first("wrap_first", 32'hFFFF_FFF0);

    // reset mid-stream with three requests outstanding
    lat = 3;
    do_reset();
    bus.imem_gnt = 1'b1;
    bus.bundle_ready = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    #1;
    check1("rst_mid_req", bus.imem_req, 1'b0);
    check1("rst_mid_valid", bus.bundle_valid, 1'b0);
    check32("rst_mid_pc", bus.bundle_pc, 32'h0);
    rst = 1'b0;
    step();
    #1;
    check1("restart_req", bus.imem_req, 1'b1);
    check32("restart_addr", bus.imem_addr, 32'h0);
    expect_first("restart_first", 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
